// File: rtl/hex_scan_display.sv
// ---------------------------------------------------------------------------
// hex_scan_display
//
// Time-multiplexed driver for DIGITS common-anode seven-segment digits.
// A packed hex word is latched and then shown one digit per refresh slot.
// Leading zero digits can be blanked, and each digit has a decimal point.
// A single all-off anode cycle separates consecutive digits to avoid ghosting.
//
// Parameters
//   DIGITS      : number of scanned digits (1..8); BIN is 4*DIGITS bits wide
//   REFRESH_DIV : clock cycles per digit slot (>= 2)
//   BLANK_LZ    : 1 = blank leading zero digits, 0 = show every digit
//
// Ports
//   Clock  in   system clock, rising-edge active
//   Resetn in   asynchronous active-low reset
//   BIN    in   value to display; nibble i drives digit i (digit 0 = LSD)
//   DP     in   decimal-point request per digit, 1 = lit
//   LOAD   in   latches BIN and DP on a rising edge while high
//   EN     in   1 = display on, 0 = all anodes off (scan keeps running)
//   AN     out  digit select, active-low, at most one bit low
//   SEG    out  segments [0:6] = a..g, active-low, registered
//   SEG_DP out  decimal point, active-low, registered
// ---------------------------------------------------------------------------
module hex_scan_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [4*DIGITS-1:0]   BIN,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  LOAD,
    input  logic                  EN,
    output logic [DIGITS-1:0]     AN,
    output logic [0:6]            SEG,
    output logic                  SEG_DP
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    // Nibble to active-low a..g pattern (bit 6 = a, bit 0 = g).
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0001100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [PW-1:0]       presc_r;
    logic [IW-1:0]       idx_r;
    logic                gap_r;
    logic                start_r;
    logic [4*DIGITS-1:0] val_r;
    logic [DIGITS-1:0]   dp_r;
    logic [DIGITS-1:0]   an_r;
    logic [0:6]          seg_r;
    logic                seg_dp_r;

    logic                tick_s;
    logic [PW-1:0]       presc_nxt_s;
    logic [IW-1:0]       idx_nxt_s;
    logic [IW+1:0]       shift_s;
    logic [4*DIGITS-1:0] shifted_s;
    logic                blank_s;
    logic                dp_bit_s;
    logic [DIGITS-1:0]   an_digit_s;
    logic [0:6]          seg_nxt_s;
    logic                upd_s;

    // Slot timing, current-digit decode and anode pattern.
    always_comb begin
        tick_s      = (presc_r == PRESC_MAX);
        presc_nxt_s = presc_r + PW'(1);
        idx_nxt_s   = idx_r;
        if (tick_s) begin
            presc_nxt_s = {PW{1'b0}};
            if (idx_r == IDX_MAX) begin
                idx_nxt_s = {IW{1'b0}};
            end else begin
                idx_nxt_s = idx_r + IW'(1);
            end
        end else begin
            idx_nxt_s = idx_r;
        end

        // Shifting the value down by the digit index puts the current
        // nibble at the bottom; the digit is a leading zero exactly when
        // everything from that nibble upward is zero.
        shift_s   = {idx_r, 2'b00};
        shifted_s = val_r >> shift_s;
        blank_s   = BLANK_LZ && (idx_r != {IW{1'b0}}) && (shifted_s == {(4*DIGITS){1'b0}});
        if (blank_s) begin
            seg_nxt_s = 7'b1111111;
        end else begin
            seg_nxt_s = hex_to_seg(shifted_s[3:0]);
        end

        dp_bit_s   = 1'b0;
        an_digit_s = {DIGITS{1'b1}};
        for (int i = 0; i < DIGITS; i++) begin
            dp_bit_s      = dp_bit_s | ((idx_r == IW'(i)) & dp_r[i]);
            an_digit_s[i] = (idx_r != IW'(i));
        end

        // Segments refresh only at a slot start (the gap cycle) so that a
        // LOAD in mid-slot cannot disturb the digit being shown. start_r
        // forces one refresh right after reset for the first slot.
        upd_s = gap_r | start_r;
    end

    // Prescaler, digit index, gap flag and post-reset refresh flag.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            presc_r <= {PW{1'b0}};
            idx_r   <= {IW{1'b0}};
            gap_r   <= 1'b0;
            start_r <= 1'b1;
        end else begin
            presc_r <= presc_nxt_s;
            idx_r   <= idx_nxt_s;
            gap_r   <= tick_s;
            start_r <= 1'b0;
        end
    end

    // Value and decimal-point latch.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            val_r <= {(4*DIGITS){1'b0}};
            dp_r  <= {DIGITS{1'b0}};
        end else if (LOAD) begin
            val_r <= BIN;
            dp_r  <= DP;
        end else begin
            val_r <= val_r;
            dp_r  <= dp_r;
        end
    end

    // Registered display outputs; the tick edge blanks the anodes for the gap.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            an_r     <= {DIGITS{1'b1}};
            seg_r    <= 7'b1111111;
            seg_dp_r <= 1'b1;
        end else begin
            if (tick_s || !EN) begin
                an_r <= {DIGITS{1'b1}};
            end else begin
                an_r <= an_digit_s;
            end
            if (upd_s) begin
                seg_r    <= seg_nxt_s;
                seg_dp_r <= ~dp_bit_s;
            end else begin
                seg_r    <= seg_r;
                seg_dp_r <= seg_dp_r;
            end
        end
    end

    assign AN     = an_r;
    assign SEG    = seg_r;
    assign SEG_DP = seg_dp_r;

    hex_scan_display_chk #(
        .DIGITS (DIGITS)
    ) u_chk (
        .clk    (Clock),
        .rst_n  (Resetn),
        .tick_s (tick_s),
        .upd_s  (upd_s),
        .an     (an_r),
        .seg    (seg_r)
    );

endmodule

// ---------------------------------------------------------------------------
// hex_scan_display_chk
//
// Protocol checks for hex_scan_display: anodes are never more than one-hot
// low, the cycle after a tick is all-off, and segments hold between slot
// starts.
//
// Ports
//   clk, rst_n : clock and asynchronous active-low reset of the display
//   tick_s     : end-of-slot strobe
//   upd_s      : segment refresh strobe
//   an, seg    : registered display outputs
// ---------------------------------------------------------------------------
module hex_scan_display_chk #(
    parameter int DIGITS = 4
) (
    input logic              clk,
    input logic              rst_n,
    input logic              tick_s,
    input logic              upd_s,
    input logic [DIGITS-1:0] an,
    input logic [0:6]        seg
);

    a_an_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(~an));

    a_gap_after_tick: assert property (@(posedge clk) disable iff (!rst_n)
        tick_s |=> (an == {DIGITS{1'b1}}));

    a_seg_hold: assert property (@(posedge clk) disable iff (!rst_n)
        !upd_s |=> $stable(seg));

endmodule

// File: tb/tb_hex_scan_display.sv
// ---------------------------------------------------------------------------
// tb_hex_scan_display
//
// Two instances (leading-zero blanking on and off) share one stimulus stream
// with DIGITS=4, REFRESH_DIV=4. Slot n starts right after edge 4n+1 following
// reset release and shows digit n%4 from the value latched by edge 4n.
// Expected per-slot segments are queued by the stimulus; a monitor pops them
// at each slot's first and last displayed cycle. Anodes are checked every
// cycle against the slot timing.
// ---------------------------------------------------------------------------
module tb_hex_scan_display;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [15:0] BIN;
    logic [3:0]  DP;
    logic        LOAD;
    logic        EN;
    logic [3:0]  AN,  AN2;
    logic [0:6]  SEG, SEG2;
    logic        SEG_DP, SEG_DP2;

    typedef struct {
        int         slot;
        logic [6:0] seg;
        logic [6:0] seg_nb;
        logic       dpn;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    logic last_en  = 1'b1;

    always #5 Clock = ~Clock;

    hex_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut (
        .Clock(Clock), .Resetn(Resetn), .BIN(BIN), .DP(DP), .LOAD(LOAD),
        .EN(EN), .AN(AN), .SEG(SEG), .SEG_DP(SEG_DP)
    );

    hex_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut_nb (
        .Clock(Clock), .Resetn(Resetn), .BIN(BIN), .DP(DP), .LOAD(LOAD),
        .EN(EN), .AN(AN2), .SEG(SEG2), .SEG_DP(SEG_DP2)
    );

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b want %b", name, edge_cnt, got, want);
        end
    endtask

    // Edge counter since reset release and EN as seen by each edge.
    always @(posedge Clock) begin
        if (!Resetn) begin
            edge_cnt = 0;
        end else begin
            edge_cnt = edge_cnt + 1;
            last_en  = EN;
        end
    end

    // Monitor: per-cycle anode timing plus scoreboard compare at slot bounds.
    always @(negedge Clock) begin
        if (Resetn && edge_cnt >= 1) begin
            automatic int         k = edge_cnt;
            automatic int         n = (k - 1) / 4;
            automatic logic [3:0] e;
            if (!last_en || (k % 4) == 0) e = 4'hF;
            else                          e = ~(4'b0001 << (n % 4));
            check("an", {3'b000, AN}, {3'b000, e});
            check("an_nb", {3'b000, AN2}, {3'b000, e});
            if ((k % 4) == 1 || (k % 4) == 3) begin
                while (sb_q.size() > 0 && sb_q[0].slot < n) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL missed_slot: slot %0d never checked, now at slot %0d", sb_q[0].slot, n);
                    void'(sb_q.pop_front());
                end
                if (sb_q.size() > 0 && sb_q[0].slot == n) begin
                    check($sformatf("seg slot%0d", n), SEG, sb_q[0].seg);
                    check($sformatf("seg_nb slot%0d", n), SEG2, sb_q[0].seg_nb);
                    check($sformatf("seg_dp slot%0d", n), {6'b0, SEG_DP}, {6'b0, sb_q[0].dpn});
                    check($sformatf("seg_dp_nb slot%0d", n), {6'b0, SEG_DP2}, {6'b0, sb_q[0].dpn});
                    if ((k % 4) == 3) void'(sb_q.pop_front());
                end
            end
        end
    end

    // Queue the four slots n0..n0+3 (digits 0..3); dpn bit i is digit i's SEG_DP.
    task automatic push_frame(input int n0,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [6:0] b0, input logic [6:0] b1,
                              input logic [6:0] b2, input logic [6:0] b3,
                              input logic [3:0] dpn);
        sb_q.push_back('{n0,     s0, b0, dpn[0]});
        sb_q.push_back('{n0 + 1, s1, b1, dpn[1]});
        sb_q.push_back('{n0 + 2, s2, b2, dpn[2]});
        sb_q.push_back('{n0 + 3, s3, b3, dpn[3]});
    endtask

    // Wait (at negedges) until edge_cnt reaches target, bounded.
    task automatic wait_edge(input int target);
        for (int i = 0; i < 400 && edge_cnt != target; i++) @(negedge Clock);
        n_checks++;
        if (edge_cnt != target) begin
            n_fail++;
            $display("FAIL wait_edge timeout: edge %0d want %0d", edge_cnt, target);
        end
    endtask

    // Drive LOAD so that it is sampled high by edge e only.
    task automatic load_at(input int e, input logic [15:0] bin, input logic [3:0] dp);
        wait_edge(e - 1);
        BIN  = bin;
        DP   = dp;
        LOAD = 1'b1;
        @(negedge Clock);
        LOAD = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " an"}, {3'b000, AN}, 7'b0001111);
        check({tag, " an_nb"}, {3'b000, AN2}, 7'b0001111);
        check({tag, " seg"}, SEG, 7'b1111111);
        check({tag, " seg_nb"}, SEG2, 7'b1111111);
        check({tag, " seg_dp"}, {6'b0, SEG_DP}, 7'b0000001);
        check({tag, " seg_dp_nb"}, {6'b0, SEG_DP2}, 7'b0000001);
    endtask

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [6:0] S5 = 7'b0100100, S7 = 7'b0001111, SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0111000, SB = 7'b1111111;

    initial begin
        Resetn = 1'b0; LOAD = 1'b0; EN = 1'b1; BIN = 16'h0000; DP = 4'b0000;
        repeat (2) @(negedge Clock);
        #1 check_reset_outputs("reset");

        // Value 0 after reset: one "0" with blanking, four without.
        push_frame(0, S0, SB, SB, SB, S0, S0, S0, S0, 4'b1111);
        @(negedge Clock);
        Resetn = 1'b1;

        // 1A2F loaded on the tick edge ending slot 3.
        push_frame(4, SF, S2, SA, S1, SF, S2, SA, S1, 4'b1111);
        load_at(16, 16'h1A2F, 4'b0000);

        // 0005 loaded mid-slot of digit 3: that digit keeps "1".
        push_frame(8, S5, SB, SB, SB, S5, S0, S0, S0, 4'b1111);
        load_at(30, 16'h0005, 4'b0000);

        // Decimal point on a blanked digit.
        push_frame(12, S7, SB, SB, SB, S7, S0, S0, S0, 4'b1011);
        load_at(46, 16'h0007, 4'b0100);

        // 1111 then 2222 loaded mid-slot of digit 1.
        push_frame(16, S1, S1, S2, S2, S1, S1, S2, S2, 4'b1111);
        load_at(62, 16'h1111, 4'b0000);
        load_at(70, 16'h2222, 4'b0000);

        // EN low for edges 81..90; display resumes at digit 2 on edge 91.
        push_frame(20, S2, S2, S2, S2, S2, S2, S2, S2, 4'b1111);
        wait_edge(80);
        EN = 1'b0;
        wait_edge(90);
        EN = 1'b1;

        // Asynchronous reset in mid-slot of slot 24.
        wait_edge(98);
        #2 Resetn = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        push_frame(0, S0, SB, SB, SB, S0, S0, S0, S0, 4'b1111);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        wait_edge(20);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
